bus_trace_monitor: RTL and testbench

Synthesizable, parametrised transaction monitor for the CPU's ready/valid read buses. It observes NCH independent request/response channel pairs (e.g. instruction fetch and data load) and pairs each response with its own in-order outstanding request address. It then emits timestamped trace records through a single ready/valid trace port. Error flags report orphan responses, outstanding-queue overflow and, optionally, handshake protocol violations. It sits beside the core on the bus wiring; it never drives or back-pressures the observed buses.

---
 rtl/bus_monitor_pkg.sv | 27 ++
 rtl/monitor_addr_fifo.sv | 51 +++++
 rtl/bus_trace_monitor.sv | 219 +++++++++++++++++++++
 tb/tb_bus_trace_monitor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_monitor_pkg.sv
// Shared constants, trace record layout and helpers for bus_trace_monitor.
package bus_monitor_pkg;

    localparam int unsigned CH_W       = 3;
    localparam int unsigned DROP_W     = 16;
    localparam logic [DROP_W-1:0] DROP_SAT = {DROP_W{1'b1}};

    localparam int unsigned TS_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // Default-width record; the monitor rebuilds this same field order from its parameters.
    typedef struct packed {
        logic [TS_W_DEF-1:0]   ts;
        logic [CH_W-1:0]       ch;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } trace_rec_t;

    function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] a,
                                                       input logic [3:0]        b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + (DROP_W+1)'(b);
        return s[DROP_W] ? DROP_SAT : s[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/monitor_addr_fifo.sv
// Per-channel outstanding request address FIFO; head reads the oldest entry
// before any same-cycle write lands.
module monitor_addr_fifo #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH-1:0] push_addr_i,
    input  logic                  pop_i,
    output logic [ADDR_WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_q;
    logic [PTR_W-1:0]      rd_q;
    logic [CNT_W-1:0]      cnt_q;

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= push_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push_i && pop_i) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_trace_monitor.sv
// Passive ready/valid read-bus monitor emitting timestamped trace records.
// Optional handshake checking: BUS_MONITOR_PROTOCOL_CHECK_EN.
module bus_trace_monitor
    import bus_monitor_pkg::*;
#(
    parameter int unsigned NCH        = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TS_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH-1:0]            raddr_valid,
    input  logic [NCH-1:0]            raddr_ready,
    input  logic [NCH*ADDR_WIDTH-1:0] raddr,
    input  logic [NCH-1:0]            rdata_valid,
    input  logic [NCH-1:0]            rdata_ready,
    input  logic [NCH*DATA_WIDTH-1:0] rdata,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [TS_WIDTH-1:0]       trace_ts,
    output logic [CH_W-1:0]           trace_ch,
    output logic [ADDR_WIDTH-1:0]     trace_addr,
    output logic [DATA_WIDTH-1:0]     trace_data,
    input  logic                      err_clr,
    output logic [NCH-1:0]            err_orphan,
    output logic [NCH-1:0]            err_overflow,
    output logic [NCH-1:0]            err_protocol,
    output logic [DROP_W-1:0]         drop_count
);

    typedef struct packed {
        logic [TS_WIDTH-1:0]   ts;
        logic [CH_W-1:0]       ch;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } rec_t;

    logic [TS_WIDTH-1:0]   ts_q;
    logic [NCH-1:0]        req_hs, rsp_hs, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_WIDTH-1:0] fifo_head [NCH];
    rec_t                  slot_q [NCH];
    rec_t                  slot_d [NCH];
    logic [NCH-1:0]        slot_vld_q, slot_vld_d;
    rec_t                  out_q, grant_rec;
    logic                  out_vld_q, out_load, grant_vld;
    logic [CH_W-1:0]       rr_q, rr_next, grant_idx;
    logic [NCH-1:0]        orphan_q, overflow_q, orphan_set, overflow_set;
    logic [DROP_W-1:0]     drop_q;
    logic [3:0]            n_drop;

    assign req_hs    = raddr_valid & raddr_ready;
    assign rsp_hs    = rdata_valid & rdata_ready;
    assign fifo_pop  = rsp_hs & ~fifo_empty;
    assign fifo_push = req_hs & (~fifo_full | fifo_pop);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        monitor_addr_fifo #(
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst),
            .push_i      (fifo_push[c]),
            .push_addr_i (raddr[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .pop_i       (fifo_pop[c]),
            .head_o      (fifo_head[c]),
            .full_o      (fifo_full[c]),
            .empty_o     (fifo_empty[c])
        );
    end

    // Round-robin pick: first occupied slot at or after rr_q, then wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_rec = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!grant_vld && slot_vld_q[c] && c >= 32'(rr_q)) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(c);
                grant_rec = slot_q[c];
            end
        end
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!grant_vld && slot_vld_q[c] && c < 32'(rr_q)) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(c);
                grant_rec = slot_q[c];
            end
        end
        out_load = !out_vld_q || trace_ready;
        rr_next  = (32'(grant_idx) == NCH - 1) ? '0 : grant_idx + 1'b1;
    end

    // Slot update: a slot granted this cycle frees before a new record lands in it.
    always_comb begin
        slot_vld_d   = slot_vld_q;
        slot_d       = slot_q;
        n_drop       = '0;
        orphan_set   = '0;
        overflow_set = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (grant_vld && out_load && grant_idx == CH_W'(c)) begin
                slot_vld_d[c] = 1'b0;
            end
            if (rsp_hs[c]) begin
                if (fifo_empty[c]) begin
                    orphan_set[c] = 1'b1;
                end else if (!slot_vld_d[c]) begin
                    slot_vld_d[c]  = 1'b1;
                    slot_d[c].ts   = ts_q;
                    slot_d[c].ch   = CH_W'(c);
                    slot_d[c].addr = fifo_head[c];
                    slot_d[c].data = rdata[c*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    n_drop = n_drop + 4'd1;
                end
            end
            if (req_hs[c] && fifo_full[c] && !fifo_pop[c]) begin
                overflow_set[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            slot_vld_q <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            rr_q       <= '0;
            orphan_q   <= '0;
            overflow_q <= '0;
            drop_q     <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                slot_q[c] <= '0;
            end
        end else begin
            ts_q       <= ts_q + 1'b1;
            slot_vld_q <= slot_vld_d;
            for (int unsigned c = 0; c < NCH; c++) begin
                slot_q[c] <= slot_d[c];
            end
            if (out_load) begin
                out_vld_q <= grant_vld;
                if (grant_vld) begin
                    out_q <= grant_rec;
                    rr_q  <= rr_next;
                end
            end
            if (err_clr) begin
                orphan_q   <= '0;
                overflow_q <= '0;
                drop_q     <= '0;
            end else begin
                orphan_q   <= orphan_q | orphan_set;
                overflow_q <= overflow_q | overflow_set;
                drop_q     <= drop_sat_add(drop_q, n_drop);
            end
        end
    end

`ifdef BUS_MONITOR_PROTOCOL_CHECK_EN
    logic [NCH-1:0]            req_v_q, req_r_q, rsp_v_q, rsp_r_q, prot_set, prot_q;
    logic [NCH*ADDR_WIDTH-1:0] req_a_q;
    logic [NCH*DATA_WIDTH-1:0] rsp_d_q;

    // A stalled valid must stay up with an unchanged payload.
    always_comb begin
        prot_set = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (req_v_q[c] && !req_r_q[c] && (!raddr_valid[c] ||
                raddr[c*ADDR_WIDTH +: ADDR_WIDTH] != req_a_q[c*ADDR_WIDTH +: ADDR_WIDTH])) begin
                prot_set[c] = 1'b1;
            end
            if (rsp_v_q[c] && !rsp_r_q[c] && (!rdata_valid[c] ||
                rdata[c*DATA_WIDTH +: DATA_WIDTH] != rsp_d_q[c*DATA_WIDTH +: DATA_WIDTH])) begin
                prot_set[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_v_q <= '0;
            req_r_q <= '0;
            req_a_q <= '0;
            rsp_v_q <= '0;
            rsp_r_q <= '0;
            rsp_d_q <= '0;
            prot_q  <= '0;
        end else begin
            req_v_q <= raddr_valid;
            req_r_q <= raddr_ready;
            req_a_q <= raddr;
            rsp_v_q <= rdata_valid;
            rsp_r_q <= rdata_ready;
            rsp_d_q <= rdata;
            prot_q  <= err_clr ? '0 : (prot_q | prot_set);
        end
    end

    assign err_protocol = prot_q;
`else
    assign err_protocol = '0;
`endif

    assign trace_valid  = out_vld_q;
    assign trace_ts     = out_q.ts;
    assign trace_ch     = out_q.ch;
    assign trace_addr   = out_q.addr;
    assign trace_data   = out_q.data;
    assign err_orphan   = orphan_q;
    assign err_overflow = overflow_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_bus_trace_monitor.sv
// Directed self-checking bench for bus_trace_monitor (NCH=2, DEPTH=4, 32-bit fields).
module tb_bus_trace_monitor;
    import bus_monitor_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  raddr_valid, raddr_ready, rdata_valid, rdata_ready;
    logic [63:0] raddr, rdata;
    logic        trace_valid, trace_ready, err_clr;
    logic [31:0] trace_ts, trace_addr, trace_data;
    logic [2:0]  trace_ch;
    logic [1:0]  err_orphan, err_overflow, err_protocol;
    logic [15:0] drop_count;
    logic [98:0] rec_o;

    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc;

    bus_trace_monitor #(
        .NCH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .TS_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst),
        .raddr_valid(raddr_valid), .raddr_ready(raddr_ready), .raddr(raddr),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_ts(trace_ts),
        .trace_ch(trace_ch), .trace_addr(trace_addr), .trace_data(trace_data),
        .err_clr(err_clr), .err_orphan(err_orphan), .err_overflow(err_overflow),
        .err_protocol(err_protocol), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Reference timestamp: edges seen since reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    assign rec_o = {trace_ch, trace_addr, trace_data, trace_ts};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        raddr_valid = '0; raddr_ready = '0; raddr = '0;
        rdata_valid = '0; rdata_ready = '0; rdata = '0;
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        clear_bus();
        trace_ready = 1'b1;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", trace_valid); end
        n_cmp++; if (rec_o !== '0) begin n_fail++; $display("FAIL reset_record: got %h want 0", rec_o); end
        n_cmp++; if ({err_orphan, err_overflow, err_protocol} !== 6'd0) begin n_fail++;
            $display("FAIL reset_errors: got %b want 000000", {err_orphan, err_overflow, err_protocol}); end
        n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    endtask

    task automatic test_single();
        int unsigned ts_e;
        raddr_valid = 2'b01; raddr_ready = 2'b01; raddr[31:0] = 32'h100;
        tick();
        clear_bus();
        tick();
        rdata_valid = 2'b01; rdata_ready = 2'b01; rdata[31:0] = 32'hDEADBEEF; ts_e = cyc;
        tick();
        clear_bus();
        n_cmp++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %0b want 0", trace_valid); end
        tick();
        n_cmp++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", trace_valid); end
        n_cmp++; if (rec_o !== {3'd0, 32'h100, 32'hDEADBEEF, ts_e}) begin n_fail++;
            $display("FAIL single_record: got %h want %h", rec_o, {3'd0, 32'h100, 32'hDEADBEEF, ts_e}); end
        tick();
        n_cmp++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %0b want 0", trace_valid); end
    endtask

    task automatic test_back_to_back();
        int unsigned ts_a [4];
        for (int i = 0; i < 4; i++) begin
            raddr_valid = 2'b01; raddr_ready = 2'b01; raddr[31:0] = 32'(4 * i);
            tick();
        end
        clear_bus();
        rdata_ready = 2'b01;
        for (int i = 0; i < 4; i++) begin
            rdata_valid = 2'b01; rdata[31:0] = 32'hA0 + 32'(i); ts_a[i] = cyc;
            tick();
            if (i > 0) begin
                n_cmp++; if (trace_valid !== 1'b1 || rec_o !== {3'd0, 32'(4 * (i - 1)), 32'hA0 + 32'(i - 1), ts_a[i-1]}) begin
                    n_fail++; $display("FAIL b2b_rec%0d: got v=%0b %h want v=1 %h", i - 1, trace_valid, rec_o,
                                       {3'd0, 32'(4 * (i - 1)), 32'hA0 + 32'(i - 1), ts_a[i-1]}); end
            end
        end
        clear_bus();
        tick();
        n_cmp++; if (trace_valid !== 1'b1 || rec_o !== {3'd0, 32'hC, 32'hA3, ts_a[3]}) begin n_fail++;
            $display("FAIL b2b_rec3: got v=%0b %h want v=1 %h", trace_valid, rec_o, {3'd0, 32'hC, 32'hA3, ts_a[3]}); end
        tick();
        n_cmp++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0b want 0", trace_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'h14; exp_addr[1] = 32'h18; exp_addr[2] = 32'h1C; exp_addr[3] = 32'h24;
        for (int i = 0; i < 4; i++) begin
            raddr_valid = 2'b01; raddr_ready = 2'b01; raddr[31:0] = 32'h10 + 32'(4 * i);
            tick();
        end
        n_cmp++; if (err_overflow !== 2'b00) begin n_fail++; $display("FAIL ovf_before: got %b want 00", err_overflow); end
        raddr[31:0] = 32'h20;
        tick();
        clear_bus();
        n_cmp++; if (err_overflow !== 2'b01) begin n_fail++; $display("FAIL ovf_set: got %b want 01", err_overflow); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++; if (err_overflow !== 2'b00) begin n_fail++; $display("FAIL ovf_clr: got %b want 00", err_overflow); end
        // Push into a full queue alongside a pop is legal and pairs with the oldest entry.
        raddr_valid = 2'b01; raddr_ready = 2'b01; raddr[31:0] = 32'h24;
        rdata_valid = 2'b01; rdata_ready = 2'b01; rdata[31:0] = 32'h55;
        tick();
        clear_bus();
        n_cmp++; if (err_overflow !== 2'b00) begin n_fail++; $display("FAIL ovf_pushpop: got %b want 00", err_overflow); end
        tick();
        n_cmp++; if (trace_valid !== 1'b1 || trace_addr !== 32'h10 || trace_data !== 32'h55) begin n_fail++;
            $display("FAIL ovf_first: got v=%0b a=%h d=%h want v=1 a=10 d=55", trace_valid, trace_addr, trace_data); end
        for (int i = 0; i < 4; i++) begin
            rdata_valid = 2'b01; rdata_ready = 2'b01; rdata[31:0] = 32'h60 + 32'(i);
            tick();
            clear_bus();
            tick();
            n_cmp++; if (trace_valid !== 1'b1 || trace_addr !== exp_addr[i] || trace_data !== 32'h60 + 32'(i)) begin
                n_fail++; $display("FAIL ovf_rec%0d: got v=%0b a=%h d=%h want v=1 a=%h d=%h", i, trace_valid,
                                   trace_addr, trace_data, exp_addr[i], 32'h60 + 32'(i)); end
        end
        rdata_valid = 2'b01; rdata_ready = 2'b01; rdata[31:0] = 32'h99;
        tick();
        clear_bus();
        n_cmp++; if (err_orphan !== 2'b01 || trace_valid !== 1'b0) begin n_fail++;
            $display("FAIL ovf_empty_after4: got orphan=%b v=%0b want orphan=01 v=0", err_orphan, trace_valid); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_orphan();
        rdata_valid = 2'b10; rdata_ready = 2'b10; rdata[63:32] = 32'h1234;
        tick();
        clear_bus();
        n_cmp++; if (err_orphan !== 2'b10) begin n_fail++; $display("FAIL orphan_set: got %b want 10", err_orphan); end
        tick();
        n_cmp++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL orphan_novalid: got %0b want 0", trace_valid); end
        // Clear wins over an orphan in the same cycle.
        err_clr = 1'b1; rdata_valid = 2'b10; rdata_ready = 2'b10;
        tick();
        clear_bus();
        n_cmp++; if (err_orphan !== 2'b00) begin n_fail++; $display("FAIL orphan_clr: got %b want 00", err_orphan); end
        tick();
        n_cmp++; if (err_orphan !== 2'b00) begin n_fail++; $display("FAIL orphan_stays_clr: got %b want 00", err_orphan); end
    endtask

    task automatic test_rr_hold();
        int unsigned ts_c, ts_e;
        do_reset();
        trace_ready = 1'b0;
        raddr_valid = 2'b11; raddr_ready = 2'b11; raddr = {32'h300, 32'h200};
        tick();
        raddr_valid = 2'b01; raddr_ready = 2'b01; raddr[31:0] = 32'h204;
        tick();
        raddr[31:0] = 32'h208;
        tick();
        clear_bus();
        rdata_valid = 2'b11; rdata_ready = 2'b11; rdata = {32'h2222, 32'h1111}; ts_c = cyc;
        tick();
        clear_bus();
        tick();
        n_cmp++; if (trace_valid !== 1'b1 || rec_o !== {3'd0, 32'h200, 32'h1111, ts_c}) begin n_fail++;
            $display("FAIL rr_first: got v=%0b %h want v=1 %h", trace_valid, rec_o, {3'd0, 32'h200, 32'h1111, ts_c}); end
        rdata_valid = 2'b01; rdata_ready = 2'b01; rdata[31:0] = 32'h3333; ts_e = cyc;
        tick();
        n_cmp++; if (trace_valid !== 1'b1 || rec_o !== {3'd0, 32'h200, 32'h1111, ts_c} || drop_count !== 16'd0) begin
            n_fail++; $display("FAIL rr_hold1: got v=%0b %h drop=%0d want v=1 %h drop=0", trace_valid, rec_o,
                               drop_count, {3'd0, 32'h200, 32'h1111, ts_c}); end
        rdata[31:0] = 32'h4444;
        tick();
        clear_bus();
        n_cmp++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL rr_drop: got %0d want 1", drop_count); end
        n_cmp++; if (trace_valid !== 1'b1 || rec_o !== {3'd0, 32'h200, 32'h1111, ts_c}) begin n_fail++;
            $display("FAIL rr_hold2: got v=%0b %h want v=1 %h", trace_valid, rec_o, {3'd0, 32'h200, 32'h1111, ts_c}); end
        trace_ready = 1'b1;
        tick();
        n_cmp++; if (trace_valid !== 1'b1 || rec_o !== {3'd1, 32'h300, 32'h2222, ts_c}) begin n_fail++;
            $display("FAIL rr_second: got v=%0b %h want v=1 %h", trace_valid, rec_o, {3'd1, 32'h300, 32'h2222, ts_c}); end
        tick();
        n_cmp++; if (trace_valid !== 1'b1 || rec_o !== {3'd0, 32'h204, 32'h3333, ts_e}) begin n_fail++;
            $display("FAIL rr_third: got v=%0b %h want v=1 %h", trace_valid, rec_o, {3'd0, 32'h204, 32'h3333, ts_e}); end
        tick();
        n_cmp++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %0b want 0", trace_valid); end
    endtask

    task automatic test_async_reset();
        raddr_valid = 2'b01; raddr_ready = 2'b01; raddr[31:0] = 32'h500;
        tick();
        clear_bus();
        rdata_valid = 2'b01; rdata_ready = 2'b01; rdata[31:0] = 32'h77;
        tick();
        clear_bus();
        trace_ready = 1'b0;
        tick();
        n_cmp++; if (trace_valid !== 1'b1 || drop_count !== 16'd1) begin n_fail++;
            $display("FAIL arst_pending: got v=%0b drop=%0d want v=1 drop=1", trace_valid, drop_count); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (trace_valid !== 1'b0 || drop_count !== 16'd0 || rec_o !== '0) begin n_fail++;
            $display("FAIL arst_immediate: got v=%0b drop=%0d rec=%h want all 0", trace_valid, drop_count, rec_o); end
        n_cmp++; if ({err_orphan, err_overflow, err_protocol} !== 6'd0) begin n_fail++;
            $display("FAIL arst_errors: got %b want 000000", {err_orphan, err_overflow, err_protocol}); end
        @(posedge clk);
        #1 rst = 1'b1;
        trace_ready = 1'b1;
        // Push at the first edge after release (ts 0), respond at the third (ts 2).
        raddr_valid = 2'b10; raddr_ready = 2'b10; raddr[63:32] = 32'h600;
        tick();
        clear_bus();
        tick();
        rdata_valid = 2'b10; rdata_ready = 2'b10; rdata[63:32] = 32'h88;
        tick();
        clear_bus();
        tick();
        n_cmp++; if (trace_valid !== 1'b1 || rec_o !== {3'd1, 32'h600, 32'h88, 32'd2}) begin n_fail++;
            $display("FAIL arst_ts_restart: got v=%0b %h want v=1 %h", trace_valid, rec_o, {3'd1, 32'h600, 32'h88, 32'd2}); end
        tick();
    endtask

    task automatic test_protocol();
        logic [1:0] exp_prot;
`ifdef BUS_MONITOR_PROTOCOL_CHECK_EN
        exp_prot = 2'b10;
`else
        exp_prot = 2'b00;
`endif
        n_cmp++; if (err_protocol !== 2'b00) begin n_fail++; $display("FAIL prot_initial: got %b want 00", err_protocol); end
        raddr_valid = 2'b10; raddr_ready = 2'b00; raddr[63:32] = 32'h40;
        tick();
        n_cmp++; if (err_protocol !== 2'b00) begin n_fail++; $display("FAIL prot_stall_ok: got %b want 00", err_protocol); end
        raddr_valid = 2'b00;
        tick();
        n_cmp++; if (err_protocol !== exp_prot) begin n_fail++; $display("FAIL prot_drop: got %b want %b", err_protocol, exp_prot); end
        clear_bus();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++; if (err_protocol !== 2'b00) begin n_fail++; $display("FAIL prot_clr: got %b want 00", err_protocol); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        trace_ready = 1'b1;
        clear_bus();
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_orphan();
        test_rr_hold();
        test_async_reset();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
